// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter
// Merges NUM_PORTS AXI-Stream slave inputs onto one registered master output.
// A grant is taken in IDLE, held in BUSY for a whole packet (or a single beat
// when LOCK_PACKET is 0), and the source index travels with each beat on
// m_axis_tid. Arbitration is round-robin (ARB_MODE 0) or fixed priority with
// the lowest index winning (ARB_MODE 1).
module axis_rr_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ARB_MODE    = 0,
    parameter int LOCK_PACKET = 1,
    localparam int IDW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            axis_aclk,
    input  logic                            axis_areset,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [IDW-1:0]                  m_axis_tid,
    output logic                            busy
);

    // Grant FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // After reset the pointer sits on the last port so port 0 is searched first
    localparam logic [IDW-1:0] LAST_PORT = IDW'(NUM_PORTS - 1);

    // Grant state
    logic [0:0]            state_q;
    logic [0:0]            state_d;
    logic [IDW-1:0]        grant_q;
    logic [IDW-1:0]        grant_d;
    logic [IDW-1:0]        last_grant_q;
    logic [IDW-1:0]        last_grant_d;

    // Output register
    logic                  m_tvalid_q;
    logic                  m_tvalid_d;
    logic                  m_tlast_q;
    logic                  m_tlast_d;
    logic [DATA_WIDTH-1:0] m_tdata_q;
    logic [DATA_WIDTH-1:0] m_tdata_d;
    logic [IDW-1:0]        m_tid_q;
    logic [IDW-1:0]        m_tid_d;

    // Arbitration search results
    logic                  hi_found_s;
    logic                  lo_found_s;
    logic [IDW-1:0]        hi_idx_s;
    logic [IDW-1:0]        lo_idx_s;
    logic [IDW-1:0]        win_idx_s;
    logic                  any_req_s;

    // Granted-port view and handshake terms
    logic                  sel_valid_s;
    logic                  sel_tlast_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic                  busy_s;
    logic                  out_free_s;
    logic                  accept_s;
    logic                  pkt_end_s;
    logic [NUM_PORTS-1:0]  ready_s;

    // Request search: hi pass covers ports above last_grant, lo pass covers all
    // ports, so "hi if found else lo" is the wrapped round-robin search and
    // "lo" alone is the fixed-priority search.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            hi_idx_s   = (s_axis_tvalid[i] && !hi_found_s && (i > int'(last_grant_q)))
                         ? IDW'(i) : hi_idx_s;
            hi_found_s = hi_found_s | (s_axis_tvalid[i] & (i > int'(last_grant_q)));
            lo_idx_s   = (s_axis_tvalid[i] && !lo_found_s) ? IDW'(i) : lo_idx_s;
            lo_found_s = lo_found_s | s_axis_tvalid[i];
        end
    end

    assign any_req_s = lo_found_s;
    assign win_idx_s = ((ARB_MODE == 0) && hi_found_s) ? hi_idx_s : lo_idx_s;

    // Granted-port mux built as an AND-OR tree over a one-hot compare
    always_comb begin
        sel_valid_s = 1'b0;
        sel_tlast_s = 1'b0;
        sel_data_s  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sel_valid_s = sel_valid_s | ((grant_q == IDW'(i)) & s_axis_tvalid[i]);
            sel_tlast_s = sel_tlast_s | ((grant_q == IDW'(i)) & s_axis_tlast[i]);
            sel_data_s  = sel_data_s
                        | ({DATA_WIDTH{grant_q == IDW'(i)}} & s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Ready depends only on grant state and output-register space, never on tvalid
    assign busy_s     = (state_q == ST_BUSY);
    assign out_free_s = ~m_tvalid_q | m_axis_tready;

    // One-hot ready toward the granted port only
    always_comb begin
        ready_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            ready_s[i] = busy_s & out_free_s & (grant_q == IDW'(i));
        end
    end

    assign accept_s  = sel_valid_s & busy_s & out_free_s;
    assign pkt_end_s = accept_s & (sel_tlast_s | (LOCK_PACKET == 0));

    // Grant FSM next state: arbitrate in IDLE, release at the end of the packet
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d      = ST_BUSY;
                    grant_d      = win_idx_s;
                    last_grant_d = win_idx_s;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (pkt_end_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grant FSM registers
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_PORT;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Output register next state: load on acceptance, drain when taken downstream
    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tdata_d  = m_tdata_q;
        m_tid_d    = m_tid_q;
        if (accept_s) begin
            m_tvalid_d = 1'b1;
            m_tlast_d  = sel_tlast_s;
            m_tdata_d  = sel_data_s;
            m_tid_d    = grant_q;
        end else if (m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end else begin
            m_tvalid_d = m_tvalid_q;
        end
    end

    // Output registers; reset drops any in-flight beat
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tdata_q  <= '0;
            m_tid_q    <= '0;
        end else begin
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tdata_q  <= m_tdata_d;
            m_tid_q    <= m_tid_d;
        end
    end

    assign s_axis_tready = ready_s;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tid    = m_tid_q;
    assign busy          = busy_s;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: three instances (round-robin/locked, fixed
// priority/locked, round-robin/per-beat) fed from per-port beat queues, a
// transaction-rule model checked every cycle, plus literal expectations on
// the collected output beats.
module tb_axis_rr_arbiter;

    localparam int NP = 4;
    localparam int DW = 16;
    localparam int NI = 3;
    localparam int QD = 64;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    logic [NP*DW-1:0] sdata [NI];
    logic [NP-1:0]    svld  [NI];
    logic [NP-1:0]    slast [NI];
    logic [NP-1:0]    srdy  [NI];
    logic [DW-1:0]    mdata [NI];
    logic             mval  [NI];
    logic             mrdy  [NI];
    logic             mlast [NI];
    logic [1:0]       mid   [NI];
    logic             mbusy [NI];

    // Source queues: bit DW is tlast
    logic [DW:0]   qmem  [NI][NP][QD];
    int            qhead [NI][NP];
    int            qtail [NI][NP];
    logic [NP-1:0] acc_f [NI];
    logic          bp_en [NI];
    int            first_v [NI];

    // Observed output beats
    logic [DW-1:0] obs_d  [NI][QD];
    logic [1:0]    obs_id [NI][QD];
    logic          obs_l  [NI][QD];
    int            obs_c  [NI][QD];
    int            obs_n  [NI];

    // Model state
    logic          mdl_held [NI];
    logic [1:0]    mdl_g    [NI];
    logic [1:0]    mdl_lg   [NI];
    logic          mdl_ov   [NI];
    logic [DW-1:0] mdl_od   [NI];
    logic          mdl_ol   [NI];
    logic [1:0]    mdl_oid  [NI];

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    axis_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ARB_MODE(0), .LOCK_PACKET(1)) u_rr (
        .axis_aclk(clk), .axis_areset(rst),
        .s_axis_tdata(sdata[0]), .s_axis_tvalid(svld[0]), .s_axis_tready(srdy[0]), .s_axis_tlast(slast[0]),
        .m_axis_tdata(mdata[0]), .m_axis_tvalid(mval[0]), .m_axis_tready(mrdy[0]), .m_axis_tlast(mlast[0]),
        .m_axis_tid(mid[0]), .busy(mbusy[0]));

    axis_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ARB_MODE(1), .LOCK_PACKET(1)) u_fp (
        .axis_aclk(clk), .axis_areset(rst),
        .s_axis_tdata(sdata[1]), .s_axis_tvalid(svld[1]), .s_axis_tready(srdy[1]), .s_axis_tlast(slast[1]),
        .m_axis_tdata(mdata[1]), .m_axis_tvalid(mval[1]), .m_axis_tready(mrdy[1]), .m_axis_tlast(mlast[1]),
        .m_axis_tid(mid[1]), .busy(mbusy[1]));

    axis_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ARB_MODE(0), .LOCK_PACKET(0)) u_nl (
        .axis_aclk(clk), .axis_areset(rst),
        .s_axis_tdata(sdata[2]), .s_axis_tvalid(svld[2]), .s_axis_tready(srdy[2]), .s_axis_tlast(slast[2]),
        .m_axis_tdata(mdata[2]), .m_axis_tvalid(mval[2]), .m_axis_tready(mrdy[2]), .m_axis_tlast(mlast[2]),
        .m_axis_tid(mid[2]), .busy(mbusy[2]));

    function automatic int mode_of(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    function automatic int lock_of(input int k);
        return (k == 2) ? 0 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs = vecs + 1;
        if (act !== exp) begin
            errs = errs + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mdl_reset(input int k);
        mdl_held[k] = 1'b0;
        mdl_g[k]    = 2'd0;
        mdl_lg[k]   = 2'(NP - 1);
        mdl_ov[k]   = 1'b0;
        mdl_od[k]   = '0;
        mdl_ol[k]   = 1'b0;
        mdl_oid[k]  = 2'd0;
    endtask

    // What happens at the coming clock edge, from the arbitration rules
    task automatic mdl_step(input int k);
        logic       acc;
        logic       found;
        int         w;
        int         c;
        logic [1:0] gi;
        gi    = mdl_g[k];
        acc   = mdl_held[k] && (!mdl_ov[k] || mrdy[k]) && svld[k][gi];
        found = 1'b0;
        w     = 0;
        if (acc) begin
            mdl_ov[k]  = 1'b1;
            mdl_od[k]  = sdata[k][gi*DW +: DW];
            mdl_ol[k]  = slast[k][gi];
            mdl_oid[k] = gi;
        end else if (mrdy[k]) begin
            mdl_ov[k] = 1'b0;
        end
        if (!mdl_held[k]) begin
            for (int j = 0; j < NP; j++) begin
                c = (mode_of(k) == 1) ? j : (int'(mdl_lg[k]) + 1 + j) % NP;
                if (!found && svld[k][c[1:0]]) begin
                    found = 1'b1;
                    w     = c;
                end
            end
            if (found) begin
                mdl_held[k] = 1'b1;
                mdl_g[k]    = w[1:0];
                mdl_lg[k]   = w[1:0];
            end
        end else if (acc && (slast[k][gi] || lock_of(k) == 0)) begin
            mdl_held[k] = 1'b0;
        end
    endtask

    // Compare process: check outputs against the model, record beats, advance model
    initial begin
        logic [3:0] exp_rdy;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (rst) mdl_reset(k);
                exp_rdy = (mdl_held[k] && (!mdl_ov[k] || mrdy[k])) ? (4'b0001 << mdl_g[k]) : 4'b0000;
                chk($sformatf("u%0d.s_tready", k), 32'(srdy[k]), 32'(exp_rdy));
                chk($sformatf("u%0d.ready_onehot", k), ($countones(srdy[k]) <= 1) ? 32'd1 : 32'd0, 32'd1);
                chk($sformatf("u%0d.m_tvalid", k), 32'(mval[k]), 32'(mdl_ov[k]));
                chk($sformatf("u%0d.m_tdata", k), 32'(mdata[k]), 32'(mdl_od[k]));
                chk($sformatf("u%0d.m_tlast", k), 32'(mlast[k]), 32'(mdl_ol[k]));
                chk($sformatf("u%0d.m_tid", k), 32'(mid[k]), 32'(mdl_oid[k]));
                chk($sformatf("u%0d.busy", k), 32'(mbusy[k]), 32'(mdl_held[k]));
                acc_f[k] = svld[k] & srdy[k];
                if (!rst && mval[k] && mrdy[k] && obs_n[k] < QD) begin
                    obs_d[k][obs_n[k]]  = mdata[k];
                    obs_id[k][obs_n[k]] = mid[k];
                    obs_l[k][obs_n[k]]  = mlast[k];
                    obs_c[k][obs_n[k]]  = cyc;
                    obs_n[k] = obs_n[k] + 1;
                end
                if (!rst) mdl_step(k);
            end
        end
    end

    // Source driver: present queue heads, pop on acceptance, drive m_axis_tready
    initial begin
        for (int k = 0; k < NI; k++) begin
            svld[k] = '0; slast[k] = '0; sdata[k] = '0; mrdy[k] = 1'b1;
            bp_en[k] = 1'b0; first_v[k] = -1; acc_f[k] = '0; obs_n[k] = 0;
            for (int p = 0; p < NP; p++) begin
                qhead[k][p] = 0;
                qtail[k][p] = 0;
            end
        end
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NI; k++) begin
                for (int p = 0; p < NP; p++) begin
                    if (acc_f[k][p] && (qhead[k][p] != qtail[k][p])) qhead[k][p] = qhead[k][p] + 1;
                    if (!rst && (qhead[k][p] != qtail[k][p])) begin
                        svld[k][p]             = 1'b1;
                        sdata[k][p*DW +: DW]   = qmem[k][p][qhead[k][p]][DW-1:0];
                        slast[k][p]            = qmem[k][p][qhead[k][p]][DW];
                    end else begin
                        svld[k][p]  = 1'b0;
                        slast[k][p] = 1'b0;
                    end
                end
                if (svld[k] != 4'b0000 && first_v[k] < 0) first_v[k] = cyc;
                mrdy[k] = bp_en[k] ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    task automatic push(input int k, input int p, input int d, input logic l);
        qmem[k][p][qtail[k][p]] = {l, 16'(d)};
        qtail[k][p] = qtail[k][p] + 1;
    endtask

    task automatic flush_all();
        for (int k = 0; k < NI; k++) begin
            obs_n[k] = 0;
            first_v[k] = -1;
            for (int p = 0; p < NP; p++) qhead[k][p] = qtail[k][p];
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        flush_all();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        flush_all();
        @(posedge clk);
        #2;
    endtask

    // Wait (bounded) for n output beats, then confirm no extra beats follow
    task automatic wait_obs(input int k, input int n, input int budget);
        int t;
        t = 0;
        while (obs_n[k] < n && t < budget) begin
            @(posedge clk);
            t = t + 1;
        end
        repeat (4) @(posedge clk);
        chk($sformatf("u%0d.beat_count", k), 32'(obs_n[k]), 32'(n));
        #2;
    endtask

    initial begin
        int t;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // Single port, 10-beat packet
        do_reset();
        for (int i = 1; i <= 10; i++) push(0, 0, i, (i == 10));
        wait_obs(0, 10, 100);
        for (int i = 0; i < 10; i++) begin
            chk("single.data", 32'(obs_d[0][i]), 32'(i + 1));
            chk("single.tid", 32'(obs_id[0][i]), 32'd0);
            chk("single.tlast", 32'(obs_l[0][i]), (i == 9) ? 32'd1 : 32'd0);
        end
        chk("single.latency", 32'(obs_c[0][0] - first_v[0]), 32'd2);
        chk("single.throughput", 32'(obs_c[0][9] - obs_c[0][0]), 32'd9);

        // Round-robin fairness: two 3-beat packets per port
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++)
                for (int j = 0; j < 3; j++) push(0, p, p * 16 + j, (j == 2));
        wait_obs(0, 24, 300);
        for (int i = 0; i < 24; i++) begin
            chk("rr.tid", 32'(obs_id[0][i]), 32'((i / 3) % 4));
            chk("rr.data", 32'(obs_d[0][i]), 32'(((i / 3) % 4) * 16 + i % 3));
            chk("rr.tlast", 32'(obs_l[0][i]), (i % 3 == 2) ? 32'd1 : 32'd0);
            if (i > 0) chk("rr.spacing", 32'(obs_c[0][i] - obs_c[0][i-1]), (i % 3 == 0) ? 32'd2 : 32'd1);
        end

        // Fixed priority: port 1 keeps winning until it runs dry, then port 3
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int j = 0; j < 3; j++) push(1, 1, 16 + j, (j == 2));
        for (int j = 0; j < 3; j++) push(1, 3, 48 + j, (j == 2));
        wait_obs(1, 9, 200);
        for (int i = 0; i < 9; i++) begin
            chk("fp.tid", 32'(obs_id[1][i]), (i < 6) ? 32'd1 : 32'd3);
            chk("fp.data", 32'(obs_d[1][i]), (i < 6) ? 32'(16 + i % 3) : 32'(48 + i % 3));
        end

        // Backpressure: random downstream ready over a 10-beat packet
        do_reset();
        bp_en[0] = 1'b1;
        for (int i = 1; i <= 10; i++) push(0, 0, i, (i == 10));
        wait_obs(0, 10, 400);
        bp_en[0] = 1'b0;
        for (int i = 0; i < 10; i++) chk("bp.data", 32'(obs_d[0][i]), 32'(i + 1));

        // Per-beat re-arbitration: ports 0 and 2 alternate
        do_reset();
        for (int j = 0; j < 4; j++) begin
            push(2, 0, j, (j == 3));
            push(2, 2, 32 + j, (j == 3));
        end
        wait_obs(2, 8, 200);
        for (int i = 0; i < 8; i++) begin
            chk("nolock.tid", 32'(obs_id[2][i]), (i % 2 == 0) ? 32'd0 : 32'd2);
            chk("nolock.data", 32'(obs_d[2][i]), 32'(((i % 2 == 0) ? 0 : 32) + i / 2));
        end

        // Reset in the middle of a packet
        do_reset();
        for (int i = 1; i <= 10; i++) push(0, 0, i, (i == 10));
        t = 0;
        while (obs_n[0] < 5 && t < 100) begin
            @(posedge clk);
            t = t + 1;
        end
        chk("midrst.reached_beat5", (obs_n[0] >= 5) ? 32'd1 : 32'd0, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.m_tvalid", 32'(mval[0]), 32'd0);
        chk("midrst.m_tdata", 32'(mdata[0]), 32'd0);
        chk("midrst.m_tlast", 32'(mlast[0]), 32'd0);
        chk("midrst.m_tid", 32'(mid[0]), 32'd0);
        chk("midrst.busy", 32'(mbusy[0]), 32'd0);
        chk("midrst.s_tready", 32'(srdy[0]), 32'd0);
        flush_all();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        flush_all();
        for (int j = 0; j < 3; j++) begin
            push(0, 2, 192 + j, (j == 2));
            push(0, 0, 160 + j, (j == 2));
        end
        wait_obs(0, 6, 200);
        for (int i = 0; i < 6; i++) begin
            chk("postrst.tid", 32'(obs_id[0][i]), (i < 3) ? 32'd0 : 32'd2);
            chk("postrst.data", 32'(obs_d[0][i]), (i < 3) ? 32'(160 + i) : 32'(192 + i - 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Parametrised N-to-1 AXI-Stream packet arbiter that merges `NUM_PORTS` slave streams onto one master stream. It generalises the two-input arbiter with a configurable port count, data width and arbitration mode (round-robin or fixed priority), holds each grant for a whole packet up to `tlast`, and drives a registered output carrying the source port index on `m_axis_tid`. It sits between the stream producers and the single downstream consumer.

## Interface
- `NUM_PORTS`, 4: number of slave inputs, 1..16.
- `DATA_WIDTH`, 32: tdata width in bits.
- `ARB_MODE`, 0: 0 = round-robin; 1 = fixed priority, where the lowest index wins.
- `LOCK_PACKET`, 1: 1 = hold the grant until the `tlast` beat is accepted; 0 = re-arbitrate after every accepted beat.
- `IDW`, derived: max(1, clog2(`NUM_PORTS`)).
- `axis_aclk`  in  1  sole clock; all state updates on the rising edge.
- `axis_areset`  in  1  asynchronous, active-high reset.
- `s_axis_tdata`  in  `NUM_PORTS*DATA_WIDTH`  port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_axis_tvalid`  in  `NUM_PORTS`  per-port valid.
- `s_axis_tready`  out  `NUM_PORTS`  per-port ready; at most one bit high.
- `s_axis_tlast`  in  `NUM_PORTS`  per-port end of packet.
- `m_axis_tdata`  out  `DATA_WIDTH`  merged data, registered.
- `m_axis_tvalid`  out  1  merged valid, registered.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  merged tlast, registered.
- `m_axis_tid`  out  `IDW`  index of the source port of the current beat.
- `busy`  out  1  high while a grant is held.

## Operation
- FSM states:
  - IDLE: no grant is held.
    - When any `s_axis_tvalid` bit is high, select a winner, register the grant index, go to BUSY.
    - When no bit is high, stay in IDLE.
  - BUSY: the granted port is connected to the output.
    - Exit to IDLE on the clock edge where the granted port's beat is accepted and either (its `tlast` is 1 and `LOCK_PACKET`=1) or `LOCK_PACKET`=0.
- Round-robin selection:
  - Search begins at (last_grant+1) mod `NUM_PORTS`, wraps, and takes the first set valid.
  - last_grant is updated when the grant is issued.
  - Reset value of last_grant is `NUM_PORTS`-1, so port 0 has first priority after reset.
- Fixed priority: the lowest set index wins; last_grant is ignored.
- Ready:
  - `s_axis_tready[g]` = BUSY & (!`m_axis_tvalid` | `m_axis_tready`), where g is the granted port.
  - All other ready bits are 0.
  - `tready` does not depend combinationally on `s_axis_tvalid`.
- Output register:
  - On acceptance (`s_axis_tvalid[g]` & `s_axis_tready[g]`), load tdata, tlast, tid=g, and set `m_axis_tvalid`.
  - If `m_axis_tready` is high and no new beat is loaded, clear `m_axis_tvalid`. Held data is otherwise unchanged.
- Granted port deasserts tvalid mid-packet: the grant is held indefinitely; there is no timeout; no other port is served.
- A requester that drops tvalid while the FSM is in IDLE is still granted if it was high at the arbitration edge. BUSY then waits for that port.
- `NUM_PORTS`=1: `m_axis_tid` is constant 0, and the block behaves as a packet-framed register slice.
- `busy` = (state == BUSY).

## Timing
- Reset (async assert; deassert synchronised externally) forces:
  - all `s_axis_tready` = 0;
  - `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0, `m_axis_tid` = 0, `busy` = 0;
  - state = IDLE, last_grant = `NUM_PORTS`-1.
- Reset mid-packet: the in-flight output beat is dropped, the grant is released, and no partial-packet recovery is performed.
- Arbitration cycle: a valid seen in IDLE at edge N gives a grant at N, and `tready` is high during cycle N+1.
- Data latency: a beat accepted at edge M is presented on `m_axis_tvalid` from cycle M+1.
- Minimum `s_axis_tvalid` to `m_axis_tvalid` latency is 2 cycles.
- Throughput:
  - One beat per cycle within a packet while `m_axis_tready` is held high.
  - One idle input cycle (re-arbitration) between consecutive packets.
- Backpressure: with `m_axis_tready` low and `m_axis_tvalid` high, `s_axis_tready` is 0 the same cycle. No beat is lost or duplicated.
- Output beats are stable while `m_axis_tvalid` & !`m_axis_tready`.

## Test plan
- Single port, RR mode, `NUM_PORTS`=4: port 0 sends a 10-beat packet of data 1..10 with tlast on beat 10, `m_axis_tready`=1.
  - Output is 1..10 in order, tid=0, tlast only on beat 10.
  - First output beat is 2 cycles after the first tvalid.
- Round-robin fairness: ports 0..3 each hold continuous 3-beat packets of data 0xP0..0xP2, where P is the port index.
  - Grant order is 0,1,2,3,0,1,...
  - Packets are never interleaved.
  - Exactly one bubble between packets.
- Fixed priority (`ARB_MODE`=1): ports 1 and 3 request continuously.
  - Only port 1 is served.
  - After port 1 drops tvalid following its tlast, port 3 is served next.
- Backpressure: randomise `m_axis_tready` at 50 % during a 10-beat packet.
  - Received data is exactly 1..10.
  - Output is stable while stalled.
  - At most one ready bit is ever high.
- `LOCK_PACKET`=0: ports 0 and 2 request with 4-beat streams.
  - Output tid alternates 0,2,0,2 per beat.
- Reset mid-packet: assert `axis_areset` after beat 5 of 10.
  - All outputs go to 0 asynchronously.
  - After release, a new packet from port 0 is granted first.
